// File: rtl/neuroset_pkg.sv
// Shared types and constants for the conv/dense MAC sequencer.
// FSM state encoding, tap index order and MAC boundary (prov) codes.
package neuroset_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RDWAIT,
        ST_CONV,
        ST_RESULT,
        ST_WRITE,
        ST_FIN
    } seq_state_t;

    localparam int N_TAPS = 9;

    localparam logic [3:0] TAP_CTR = 4'd0;
    localparam logic [3:0] TAP_RT  = 4'd1;
    localparam logic [3:0] TAP_LF  = 4'd2;
    localparam logic [3:0] TAP_DL  = 4'd3;
    localparam logic [3:0] TAP_UR  = 4'd4;
    localparam logic [3:0] TAP_DN  = 4'd5;
    localparam logic [3:0] TAP_UP  = 4'd6;
    localparam logic [3:0] TAP_DR  = 4'd7;
    localparam logic [3:0] TAP_UL  = 4'd8;

    localparam logic [1:0] PROV_LEFT  = 2'b11;
    localparam logic [1:0] PROV_RIGHT = 2'b10;
    localparam logic [1:0] PROV_NONE  = 2'b00;

    // Map side is at least 2, so the left and right edges never coincide.
    function automatic logic [1:0] prov_of(input logic [4:0] col, input logic [4:0] m);
        if (col == 5'd0) return PROV_LEFT;
        if (col + 5'd1 == m) return PROV_RIGHT;
        return PROV_NONE;
    endfunction

endpackage

// File: rtl/conv_tap_addr.sv
// Neighbour address generator: raw neighbour address for one tap of pixel i,
// plus in_map telling whether that neighbour lies inside the feature map.
module conv_tap_addr
    import neuroset_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic [AW-1:0] i,
    input  logic [4:0]    col,
    input  logic [4:0]    m,
    input  logic [AW-1:0] matrix2,
    input  logic [3:0]    tap,
    input  logic          dense,
    output logic [AW-1:0] rd_addr,
    output logic          in_map
);

    logic signed [AW:0] i_s;
    logic signed [AW:0] m_s;
    logic signed [AW:0] m2_s;
    logic [AW-1:0]      m_w;
    logic               top_row;
    logic               bot_row;
    logic               left_col;
    logic               right_col;

    assign i_s  = $signed({1'b0, i});
    assign m_s  = $signed({{(AW-4){1'b0}}, m});
    assign m2_s = $signed({1'b0, matrix2});
    assign m_w  = {{(AW-5){1'b0}}, m};

    // Boundary tests are done on the signed values so nothing can wrap.
    assign top_row   = i_s < m_s;
    assign bot_row   = i_s >= (m2_s - m_s);
    assign left_col  = col == 5'd0;
    assign right_col = (col + 5'd1) == m;

    always_comb begin
        rd_addr = i;
        in_map  = 1'b1;
        if (dense) begin
            rd_addr = i + {{(AW-4){1'b0}}, tap};
        end else begin
            unique case (tap)
                TAP_RT: begin rd_addr = i + AW'(1);         in_map = !right_col;             end
                TAP_LF: begin rd_addr = i - AW'(1);         in_map = !left_col;              end
                TAP_DL: begin rd_addr = i + m_w - AW'(1);   in_map = !(bot_row || left_col);  end
                TAP_UR: begin rd_addr = i - m_w + AW'(1);   in_map = !(top_row || right_col); end
                TAP_DN: begin rd_addr = i + m_w;            in_map = !bot_row;               end
                TAP_UP: begin rd_addr = i - m_w;            in_map = !top_row;               end
                TAP_DR: begin rd_addr = i + m_w + AW'(1);   in_map = !(bot_row || right_col); end
                TAP_UL: begin rd_addr = i - m_w - AW'(1);   in_map = !(top_row || left_col);  end
                default: begin rd_addr = i;                 in_map = 1'b1;                   end
            endcase
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Sequencer driving the 3x3 conv MAC and feature/result RAMs over a whole map.
// Optional dense mode is built only when DENSE_SEQ_EN is defined.
module conv_sequencer
    import neuroset_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [4:0]    matrix,
    input  logic [AW-1:0] matrix2,
    input  logic          dense_req,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          tap_load,
    output logic [3:0]    tap_sel,
    output logic [AW-1:0] i,
    output logic [1:0]    prov,
    output logic          conv_en,
    output logic          dense_en,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    input  logic          wr_ready
);

    localparam logic [AW:0] ONE_EXT    = (AW+1)'(1);
    localparam logic [AW:0] GROUP2_EXT = (AW+1)'(2 * N_TAPS);

    seq_state_t    state_q, state_d;
    logic [4:0]    m_q, m_d;
    logic [AW-1:0] m2_q, m2_d;
    logic [AW-1:0] i_q, i_d;
    logic [4:0]    col_q, col_d;
    logic [AW-1:0] g_q, g_d;
    logic [3:0]    tap_q, tap_d;
    logic [1:0]    wait_q, wait_d;
    logic          dense_q, dense_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          conv_en_q, conv_en_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]    prov_q, prov_d;
    logic [RD_LAT-1:0] ld_pipe_q, ld_pipe_d;
    logic [3:0]    sel_pipe_q [RD_LAT];
    logic [3:0]    sel_pipe_d [RD_LAT];

    logic          dense_req_eff;
    logic [4:0]    col_inc;
    logic          last_px;
    logic [AW:0]   i_ext;
    logic [AW:0]   m2_ext;
    logic [AW-1:0] tap_addr;
    logic          tap_in_map;

`ifdef DENSE_SEQ_EN
    assign dense_req_eff = dense_req;
`else
    logic dense_req_unused;
    assign dense_req_unused = dense_req;
    assign dense_req_eff    = 1'b0;
`endif

    assign i_ext  = {1'b0, i_q};
    assign m2_ext = {1'b0, m2_q};

    conv_tap_addr #(.AW(AW)) u_tap_addr (
        .i       (i_d),
        .col     (col_d),
        .m       (m_d),
        .matrix2 (m2_d),
        .tap     (tap_d),
        .dense   (dense_d),
        .rd_addr (tap_addr),
        .in_map  (tap_in_map)
    );

    // Off-map neighbours fall back to the centre pixel address.
    assign rd_addr_d = rd_en_d ? (tap_in_map ? tap_addr : i_d) : '0;

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        m2_d      = m2_q;
        i_d       = i_q;
        col_d     = col_q;
        g_d       = g_q;
        tap_d     = tap_q;
        wait_d    = wait_q;
        dense_d   = dense_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        conv_en_d = 1'b0;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        prov_d    = prov_q;
        col_inc   = (col_q + 5'd1 == m_q) ? 5'd0 : col_q + 5'd1;
        last_px   = dense_q ? ((i_ext + GROUP2_EXT) > m2_ext) : ((i_ext + ONE_EXT) == m2_ext);

        ld_pipe_d     = ld_pipe_q;
        ld_pipe_d[0]  = rd_en_q;
        sel_pipe_d[0] = rd_en_q ? tap_q : 4'd0;
        for (int k = 1; k < RD_LAT; k++) begin
            ld_pipe_d[k]  = ld_pipe_q[k-1];
            sel_pipe_d[k] = sel_pipe_q[k-1];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = matrix;
                    m2_d    = matrix2;
                    i_d     = '0;
                    col_d   = 5'd0;
                    g_d     = '0;
                    tap_d   = TAP_CTR;
                    dense_d = dense_req_eff;
                    if (matrix2 == '0 || (dense_req_eff && matrix2 < AW'(N_TAPS))) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_FETCH;
                        busy_d  = 1'b1;
                        rd_en_d = 1'b1;
                        prov_d  = dense_req_eff ? PROV_NONE : prov_of(5'd0, matrix);
                    end
                end
            end
            ST_FETCH: begin
                if (tap_q == TAP_UL) begin
                    state_d = ST_RDWAIT;
                    wait_d  = 2'd0;
                end else begin
                    tap_d   = tap_q + 4'd1;
                    rd_en_d = 1'b1;
                end
            end
            ST_RDWAIT: begin
                if (wait_q == 2'(RD_LAT - 1)) begin
                    state_d   = ST_CONV;
                    conv_en_d = 1'b1;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_CONV: begin
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                state_d   = ST_WRITE;
                wr_en_d   = 1'b1;
                wr_addr_d = dense_q ? g_q : i_q;
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    wr_en_d   = 1'b0;
                    wr_addr_d = '0;
                    if (last_px) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_FETCH;
                        tap_d   = TAP_CTR;
                        rd_en_d = 1'b1;
                        if (dense_q) begin
                            i_d = i_q + AW'(N_TAPS);
                            g_d = g_q + AW'(1);
                        end else begin
                            i_d    = i_q + AW'(1);
                            col_d  = col_inc;
                            prov_d = prov_of(col_inc, m_q);
                        end
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                dense_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            m2_q      <= '0;
            i_q       <= '0;
            col_q     <= '0;
            g_q       <= '0;
            tap_q     <= '0;
            wait_q    <= '0;
            dense_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            conv_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            prov_q    <= '0;
            ld_pipe_q <= '0;
            for (int k = 0; k < RD_LAT; k++) sel_pipe_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            m2_q      <= m2_d;
            i_q       <= i_d;
            col_q     <= col_d;
            g_q       <= g_d;
            tap_q     <= tap_d;
            wait_q    <= wait_d;
            dense_q   <= dense_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            conv_en_q <= conv_en_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            prov_q    <= prov_d;
            ld_pipe_q <= ld_pipe_d;
            for (int k = 0; k < RD_LAT; k++) sel_pipe_q[k] <= sel_pipe_d[k];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign tap_load = ld_pipe_q[RD_LAT-1];
    assign tap_sel  = sel_pipe_q[RD_LAT-1];
    assign i        = i_q;
    assign prov     = prov_q;
    assign conv_en  = conv_en_q;
    assign dense_en = dense_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer (RD_LAT=1, AW=10); dense scenario when DENSE_SEQ_EN is defined.
module tb_conv_sequencer;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    matrix;
    logic [AW-1:0] matrix2;
    logic          dense_req;
    logic          wr_ready;
    logic          busy, done, rd_en, tap_load, conv_en, dense_en, wr_en;
    logic [AW-1:0] rd_addr, i, wr_addr;
    logic [3:0]    tap_sel;
    logic [1:0]    prov;

    always #5 clk = ~clk;

    conv_sequencer #(.RD_LAT(1), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .matrix(matrix), .matrix2(matrix2),
        .dense_req(dense_req), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .tap_load(tap_load), .tap_sel(tap_sel), .i(i), .prov(prov), .conv_en(conv_en),
        .dense_en(dense_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_ready(wr_ready)
    );

    logic [47:0] all_outs;
    assign all_outs = {busy, done, rd_en, rd_addr, tap_load, tap_sel, i, prov,
                       conv_en, dense_en, wr_en, wr_addr};

    int checks = 0;
    int failures = 0;
    int done_cyc, stall_addr, stall_left, inject_cyc, wr_hold, dense_hi, busy_lo;
    int rd_log[$], wr_log[$], conv_i[$], conv_prov[$], ld_cyc[$], ld_sel[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [4:0] m, input logic [AW-1:0] m2, input logic dr);
        matrix = m; matrix2 = m2; dense_req = dr; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic hard_reset();
        rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Observes cycles 1..max_cyc after a kick, logging bus activity.
    task automatic run(input int max_cyc);
        rd_log.delete(); wr_log.delete(); conv_i.delete(); conv_prov.delete();
        ld_cyc.delete(); ld_sel.delete();
        done_cyc = -1; wr_hold = 0; dense_hi = 0; busy_lo = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            start = (c == inject_cyc);
            if (c == inject_cyc) begin matrix = 5'd4; matrix2 = 10'd16; end
            if (rd_en) rd_log.push_back(int'(rd_addr));
            if (tap_load) begin ld_cyc.push_back(c); ld_sel.push_back(int'(tap_sel)); end
            if (conv_en) begin conv_i.push_back(int'(i)); conv_prov.push_back(int'(prov)); end
            if (dense_en) dense_hi++;
            if (wr_en && int'(wr_addr) == stall_addr) wr_hold++;
            if (done) begin done_cyc = c; break; end
            if (!busy) busy_lo++;
            wr_ready = 1'b1;
            if (wr_en && int'(wr_addr) == stall_addr && stall_left > 0) begin
                wr_ready = 1'b0; stall_left--;
            end
            if (wr_en && wr_ready) wr_log.push_back(int'(wr_addr));
            tick();
        end
        start = 1'b0; wr_ready = 1'b1; inject_cyc = -1; stall_addr = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; matrix = '0; matrix2 = '0; dense_req = 1'b0; wr_ready = 1'b1;
        tick(); tick();
        checks++;
        if (all_outs !== 48'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset busy=%b done=%b exp=0,0", busy, done);
        end
    endtask

    task automatic test_full_map();
        hard_reset();
        kick(5'd3, 10'd9, 1'b0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_cycle1 got=%b exp=1", busy); end
        run(200);
        checks++;
        if (done_cyc != 118) begin failures++; $display("FAIL done_cycle got=%0d exp=118", done_cyc); end
        checks++;
        if (busy !== 1'b0 || busy_lo != 0) begin
            failures++; $display("FAIL busy_span busy_at_done=%b low_cycles=%0d exp=0,0", busy, busy_lo);
        end
        checks++;
        if (wr_log.size() != 9) begin failures++; $display("FAIL write_count got=%0d exp=9", wr_log.size()); end
        for (int k = 0; k < wr_log.size() && k < 9; k++) begin
            checks++;
            if (wr_log[k] != k) begin failures++; $display("FAIL wr_addr[%0d] got=%0d exp=%0d", k, wr_log[k], k); end
        end
        checks++;
        if (conv_i.size() != 9) begin failures++; $display("FAIL conv_pulses got=%0d exp=9", conv_i.size()); end
        for (int k = 0; k < conv_prov.size() && k < 9; k++) begin
            int ep;
            ep = (k % 3 == 0) ? 3 : ((k % 3 == 2) ? 2 : 0);
            checks++;
            if (conv_prov[k] != ep || conv_i[k] != k) begin
                failures++; $display("FAIL conv[%0d] i=%0d prov=%0d exp i=%0d prov=%0d", k, conv_i[k], conv_prov[k], k, ep);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL after_done busy=%b done=%b exp=0,0", busy, done);
        end
    endtask

    task automatic test_tap_addr();
        int exp0 [9] = '{0, 1, 0, 0, 0, 3, 0, 4, 0};
        int exp4 [9] = '{4, 5, 3, 6, 2, 7, 1, 8, 0};
        int exp8 [9] = '{8, 8, 7, 8, 8, 8, 5, 8, 4};
        hard_reset();
        kick(5'd3, 10'd9, 1'b0);
        run(200);
        checks++;
        if (rd_log.size() != 81) begin failures++; $display("FAIL rd_count got=%0d exp=81", rd_log.size()); end
        for (int t = 0; t < 9 && rd_log.size() == 81; t++) begin
            checks++;
            if (rd_log[t] != exp0[t] || rd_log[36+t] != exp4[t] || rd_log[72+t] != exp8[t]) begin
                failures++;
                $display("FAIL tap%0d_addr got=%0d/%0d/%0d exp=%0d/%0d/%0d", t,
                         rd_log[t], rd_log[36+t], rd_log[72+t], exp0[t], exp4[t], exp8[t]);
            end
        end
        checks++;
        if (ld_cyc.size() != 81) begin failures++; $display("FAIL tap_load_count got=%0d exp=81", ld_cyc.size()); end
        for (int t = 0; t < 9 && ld_cyc.size() >= 9; t++) begin
            checks++;
            if (ld_cyc[t] != t + 2 || ld_sel[t] != t) begin
                failures++; $display("FAIL tap_load[%0d] cyc=%0d sel=%0d exp cyc=%0d sel=%0d", t, ld_cyc[t], ld_sel[t], t + 2, t);
            end
        end
    endtask

    task automatic test_backpressure();
        hard_reset();
        stall_addr = 2; stall_left = 5;
        kick(5'd3, 10'd9, 1'b0);
        stall_addr = 2; stall_left = 5;
        run(250);
        checks++;
        if (wr_hold != 6) begin failures++; $display("FAIL wr_hold_cycles got=%0d exp=6", wr_hold); end
        checks++;
        if (done_cyc != 123) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=123", done_cyc); end
        checks++;
        if (conv_i.size() != 9 || wr_log.size() != 9) begin
            failures++; $display("FAIL stall_counts conv=%0d wr=%0d exp=9,9", conv_i.size(), wr_log.size());
        end
    endtask

    task automatic test_mid_reset();
        int seen, bad;
        hard_reset();
        kick(5'd3, 10'd9, 1'b0);
        seen = 0;
        for (int c = 0; c < 200 && seen == 0; c++) begin
            if (conv_en && i == 10'd3) seen = 1;
            else tick();
        end
        checks++;
        if (seen != 1) begin failures++; $display("FAIL reach_conv3 got=%0d exp=1", seen); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (all_outs !== 48'd0) begin failures++; $display("FAIL abort_outputs got=%h exp=0", all_outs); end
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            if (done || busy || rd_en || wr_en) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL abort_quiet active_cycles=%0d exp=0", bad); end
        kick(5'd3, 10'd9, 1'b0);
        checks++;
        if (i !== 10'd0 || rd_en !== 1'b1 || rd_addr !== 10'd0 || busy !== 1'b1) begin
            failures++; $display("FAIL restart i=%0d rd_en=%b rd_addr=%0d busy=%b exp 0,1,0,1", i, rd_en, rd_addr, busy);
        end
        run(200);
        checks++;
        if (done_cyc != 118) begin failures++; $display("FAIL restart_done got=%0d exp=118", done_cyc); end
    endtask

    task automatic test_empty_and_ignored_start();
        int act;
        hard_reset();
        kick(5'd3, 10'd0, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL empty_map done=%b busy=%b exp=1,0", done, busy);
        end
        act = 0;
        for (int c = 0; c < 6; c++) begin
            if (rd_en || conv_en || wr_en) act++;
            tick();
        end
        checks++;
        if (act != 0 || done !== 1'b0) begin
            failures++; $display("FAIL empty_activity act=%0d done=%b exp=0,0", act, done);
        end
        kick(5'd3, 10'd9, 1'b0);
        inject_cyc = 5;
        run(250);
        checks++;
        if (done_cyc != 118 || wr_log.size() != 9) begin
            failures++; $display("FAIL start_while_busy done=%0d writes=%0d exp=118,9", done_cyc, wr_log.size());
        end
        checks++;
        if (wr_log.size() == 9 && wr_log[8] != 8) begin
            failures++; $display("FAIL start_while_busy_last got=%0d exp=8", wr_log[8]);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_ignored got=%b exp=0", busy); end
    endtask

`ifdef DENSE_SEQ_EN
    task automatic test_dense();
        hard_reset();
        kick(5'd5, 10'd20, 1'b1);
        run(100);
        checks++;
        if (done_cyc != 27) begin failures++; $display("FAIL dense_done got=%0d exp=27", done_cyc); end
        checks++;
        if (rd_log.size() != 18) begin failures++; $display("FAIL dense_rd_count got=%0d exp=18", rd_log.size()); end
        for (int k = 0; k < rd_log.size() && k < 18; k++) begin
            checks++;
            if (rd_log[k] != k) begin failures++; $display("FAIL dense_rd[%0d] got=%0d exp=%0d", k, rd_log[k], k); end
        end
        checks++;
        if (wr_log.size() != 2 || wr_log[0] != 0 || wr_log[1] != 1) begin
            failures++; $display("FAIL dense_writes count=%0d exp=2 with addrs 0,1", wr_log.size());
        end
        checks++;
        if (conv_i.size() != 2 || conv_i[0] != 0 || conv_i[1] != 9 || conv_prov[0] != 0 || conv_prov[1] != 0) begin
            failures++; $display("FAIL dense_conv count=%0d exp=2 with i 0,9 prov 0", conv_i.size());
        end
        checks++;
        if (dense_hi != 27) begin failures++; $display("FAIL dense_en_cycles got=%0d exp=27", dense_hi); end
    endtask
`else
    task automatic test_dense();
        hard_reset();
        kick(5'd3, 10'd9, 1'b1);
        run(200);
        checks++;
        if (dense_hi != 0) begin failures++; $display("FAIL dense_en_disabled got=%0d exp=0", dense_hi); end
        checks++;
        if (done_cyc != 118 || wr_log.size() != 9) begin
            failures++; $display("FAIL dense_req_ignored done=%0d writes=%0d exp=118,9", done_cyc, wr_log.size());
        end
    endtask
`endif

    initial begin
        stall_addr = -1; stall_left = 0; inject_cyc = -1;
        test_reset();
        test_full_map();
        test_tap_addr();
        test_backpressure();
        test_mid_reset();
        test_empty_and_ignored_start();
        test_dense();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
